mod_inverse_eea: RTL and testbench

//  Parametrised modular-inverse engine for the RSA decryption datapath. Mode 0: extended Euclid,
//  res = a^-1 mod m (CRT qinv = q^-1 mod p), any operand order. Mode 1: Montgomery constant
//  res = -m^-1 mod 2^WORD (n0prime). Iterative, one shared bit-serial divider; start/done handshake.

---
 rtl/mod_inverse_eea_if.sv | 16 +
 rtl/mod_inverse_eea.sv | 198 +++++++++++++++++++
 tb/tb_mod_inverse_eea.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/mod_inverse_eea_if.sv
// Request/response bundle for the modular-inverse engine.
interface mod_inverse_eea_if #(
    parameter int unsigned WIDTH = 2048
);
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] m;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] res;
    logic             err;

    modport master (output start, mode, a, m, input busy, done, res, err);
    modport slave  (input start, mode, a, m, output busy, done, res, err);
endinterface

// File: rtl/mod_inverse_eea.sv
// Iterative modular-inverse engine.
// Mode 0: extended Euclid, res = a^-1 mod m, using one bit-serial restoring divider.
// Mode 1: Hensel lifting, res = -m^-1 mod 2^WORD (Montgomery n0prime).
module mod_inverse_eea #(
    parameter int unsigned WIDTH = 2048,
    parameter int unsigned WORD  = 32
) (
    input logic               clk,
    input logic               rst,
    mod_inverse_eea_if.slave  bus
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_DIV  = 3'd2;
    localparam logic [2:0] S_UPD  = 3'd3;
    localparam logic [2:0] S_FIX  = 3'd4;
    localparam logic [2:0] S_HEN  = 3'd5;
    localparam logic [2:0] S_DONE = 3'd6;

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam int unsigned TW = WIDTH + 2;

    logic [2:0]              state_q, state_d;
    logic                    mode_q, mode_d;
    logic [WIDTH-1:0]        m_q, m_d;
    logic [WIDTH-1:0]        r0_q, r0_d;
    logic [WIDTH-1:0]        r1_q, r1_d;
    logic [WIDTH-1:0]        rem_q, rem_d;
    logic [WIDTH-1:0]        dvd_q, dvd_d;
    logic signed [TW-1:0]    t0_q, t0_d;
    logic signed [TW-1:0]    t1_q, t1_d;
    logic signed [TW-1:0]    p_q, p_d;
    logic [WORD-1:0]         y_q, y_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [WIDTH-1:0]        res_q, res_d;
    logic                    err_q, err_d;

    logic [WIDTH:0]          rem_sh;
    logic                    qbit;
    logic [WORD-1:0]         prod;
    logic [WORD-1:0]         prod_sh;
    logic signed [TW-1:0]    m_ext;

    assign bus.busy = (state_q != S_IDLE);
    assign bus.done = (state_q == S_DONE);
    assign bus.res  = res_q;
    assign bus.err  = err_q;

    // Next-state and datapath: division step, Euclid update, final fix-up and Hensel lifting.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        m_d     = m_q;
        r0_d    = r0_q;
        r1_d    = r1_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        t0_d    = t0_q;
        t1_d    = t1_q;
        p_d     = p_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        err_d   = err_q;

        // Restoring division: shift in next dividend bit, subtract divisor when it fits.
        rem_sh  = {rem_q, dvd_q[WIDTH-1]};
        qbit    = (rem_sh >= {1'b0, r1_q});
        // Low WORD bits of m*y only; bit cnt decides whether y needs 2^cnt added.
        prod    = m_q[WORD-1:0] * y_q;
        prod_sh = prod >> cnt_q;
        m_ext   = $signed({2'b00, m_q});

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_LOAD;
                    mode_d  = bus.mode;
                    m_d     = bus.m;
                    r1_d    = bus.a;
                end
            end
            S_LOAD: begin
                r0_d  = m_q;
                dvd_d = m_q;
                rem_d = '0;
                p_d   = '0;
                t0_d  = '0;
                t1_d  = TW'(1);
                y_d   = WORD'(1);
                cnt_d = '0;
                if (!mode_q) begin
                    if (m_q < WIDTH'(2)) begin
                        err_d   = 1'b1;
                        res_d   = '0;
                        state_d = S_DONE;
                    end else if (r1_q == '0) begin
                        state_d = S_FIX;
                    end else begin
                        state_d = S_DIV;
                    end
                end else begin
                    cnt_d = CW'(1);
                    if (m_q < WIDTH'(2) || !m_q[0]) begin
                        err_d   = 1'b1;
                        res_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_HEN;
                    end
                end
            end
            S_DIV: begin
                dvd_d = dvd_q << 1;
                rem_d = qbit ? (rem_sh[WIDTH-1:0] - r1_q) : rem_sh[WIDTH-1:0];
                p_d   = (p_q <<< 1) + (qbit ? t1_q : TW'(0));
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = S_UPD;
                end
            end
            S_UPD: begin
                r0_d  = r1_q;
                r1_d  = rem_q;
                t0_d  = t1_q;
                t1_d  = t0_q - p_q;
                dvd_d = r1_q;
                rem_d = '0;
                p_d   = '0;
                cnt_d = '0;
                state_d = (rem_q == '0) ? S_FIX : S_DIV;
            end
            S_FIX: begin
                if (r0_q == WIDTH'(1)) begin
                    err_d = 1'b0;
                    res_d = WIDTH'((t0_q < 0) ? (t0_q + m_ext) : t0_q);
                end else begin
                    err_d = 1'b1;
                    res_d = '0;
                end
                state_d = S_DONE;
            end
            S_HEN: begin
                if (prod_sh[0]) begin
                    y_d = y_q | (WORD'(1) << cnt_q);
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WORD - 1)) begin
                    err_d            = 1'b0;
                    res_d            = '0;
                    res_d[WORD-1:0]  = WORD'(0) - y_d;
                    state_d          = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset that aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            mode_q  <= 1'b0;
            m_q     <= '0;
            r0_q    <= '0;
            r1_q    <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            t0_q    <= '0;
            t1_q    <= '0;
            p_q     <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            m_q     <= m_d;
            r0_q    <= r0_d;
            r1_q    <= r1_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            t0_q    <= t0_d;
            t1_q    <= t1_d;
            p_q     <= p_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_mod_inverse_eea.sv
// Directed bench for mod_inverse_eea at WIDTH=16, WORD=8.
// Latency is counted from the start cycle through the done cycle inclusive.
module tb_mod_inverse_eea;
    localparam int unsigned WIDTH = 16;
    localparam int unsigned WORD  = 8;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    mod_inverse_eea_if #(.WIDTH(WIDTH)) bus ();

    mod_inverse_eea #(.WIDTH(WIDTH), .WORD(WORD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one request, scramble inputs after acceptance, wait (bounded) for done.
    // inj >= 0 pulses a second start with other operands that many edges into the run;
    // inj_done pulses start during the done cycle.
    task automatic run_op(input string tag, input logic md, input logic [15:0] aa,
                          input logic [15:0] mm, input int inj, input bit inj_done,
                          output logic [15:0] r, output logic e, output int lat);
        bit busy_ok;
        bit got;
        int edges;
        @(negedge clk);
        bus.start = 1'b1;
        bus.mode  = md;
        bus.a     = aa;
        bus.m     = mm;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.mode  = ~md;
        bus.a     = aa ^ 16'hFFFF;
        bus.m     = 16'h1234;
        busy_ok   = 1'b1;
        got       = 1'b0;
        edges     = 0;
        @(negedge clk);
        if (!bus.busy) busy_ok = 1'b0;
        while (!got && edges < 2000) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (!bus.busy) busy_ok = 1'b0;
            if (bus.done) begin
                got = 1'b1;
            end else if (edges == inj) begin
                bus.start = 1'b1;
                bus.mode  = 1'b0;
                bus.a     = 16'd1;
                bus.m     = 16'd5;
            end else begin
                bus.start = 1'b0;
            end
        end
        check_eq({tag, " done seen"}, 64'(got), 64'd1);
        check_eq({tag, " busy held"}, 64'(busy_ok), 64'd1);
        r   = bus.res;
        e   = bus.err;
        lat = edges + 2;
        if (inj_done) begin
            bus.start = 1'b1;
            bus.mode  = 1'b0;
            bus.a     = 16'd1;
            bus.m     = 16'd5;
        end
        @(negedge clk);
        bus.start = 1'b0;
        check_eq({tag, " idle after"}, 64'({bus.busy, bus.done}), 64'd0);
    endtask

    typedef struct {
        string       tag;
        logic        md;
        logic [15:0] aa;
        logic [15:0] mm;
        logic [15:0] res;
        logic        err;
        int          lat;
        int          inj;
        bit          inj_done;
    } vec_t;

    vec_t        vecs[$];
    logic [15:0] r;
    logic        e;
    int          lat;

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.mode  = 1'b0;
        bus.a     = '0;
        bus.m     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset busy", 64'(bus.busy), 64'd0);
        check_eq("reset done", 64'(bus.done), 64'd0);
        check_eq("reset res",  64'(bus.res),  64'd0);
        check_eq("reset err",  64'(bus.err),  64'd0);
        rst = 1'b0;

        // tag, mode, a, m, res, err, latency, inject edge, inject at done
        vecs.push_back('{"inv3_7",     1'b0, 16'd3,  16'd7,    16'd5,    1'b0, 38, -1, 1'b0});
        vecs.push_back('{"inv17_3120", 1'b0, 16'd17, 16'd3120, 16'd2753, 1'b0, 72, -1, 1'b0});
        vecs.push_back('{"inv10_7",    1'b0, 16'd10, 16'd7,    16'd5,    1'b0, 72, -1, 1'b0});
        vecs.push_back('{"inv1_7",     1'b0, 16'd1,  16'd7,    16'd1,    1'b0, 21, -1, 1'b0});
        vecs.push_back('{"gcd6_9",     1'b0, 16'd6,  16'd9,    16'd0,    1'b1, 38, -1, 1'b0});
        vecs.push_back('{"zero_9",     1'b0, 16'd0,  16'd9,    16'd0,    1'b1, 4,  -1, 1'b0});
        vecs.push_back('{"m_one",      1'b0, 16'd3,  16'd1,    16'd0,    1'b1, 3,  -1, 1'b0});
        vecs.push_back('{"n0p_15",     1'b1, 16'd0,  16'h000F, 16'd17,   1'b0, 10, -1, 1'b0});
        vecs.push_back('{"n0p_7",      1'b1, 16'd9,  16'd7,    16'd73,   1'b0, 10, -1, 1'b1});
        vecs.push_back('{"n0p_even",   1'b1, 16'd0,  16'h0010, 16'd0,    1'b1, 3,  -1, 1'b0});
        vecs.push_back('{"restart",    1'b0, 16'd3,  16'd7,    16'd5,    1'b0, 38, 10, 1'b1});

        foreach (vecs[i]) begin
            run_op(vecs[i].tag, vecs[i].md, vecs[i].aa, vecs[i].mm, vecs[i].inj,
                   vecs[i].inj_done, r, e, lat);
            check_eq({vecs[i].tag, " res"}, 64'(r),   64'(vecs[i].res));
            check_eq({vecs[i].tag, " err"}, 64'(e),   64'(vecs[i].err));
            check_eq({vecs[i].tag, " lat"}, 64'(lat), 64'(vecs[i].lat));
            if (vecs[i].tag == "inv17_3120")
                check_eq("inv17_3120 product", 64'((32'd17 * 32'(r)) % 32'd3120), 64'd1);
        end

        // Abort mid-division: outputs clear on the following cycle, no done pulse.
        @(negedge clk);
        bus.start = 1'b1;
        bus.mode  = 1'b0;
        bus.a     = 16'd17;
        bus.m     = 16'd3120;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check_eq("pre-abort busy", 64'(bus.busy), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_eq("abort busy", 64'(bus.busy), 64'd0);
        check_eq("abort done", 64'(bus.done), 64'd0);
        check_eq("abort res",  64'(bus.res),  64'd0);
        check_eq("abort err",  64'(bus.err),  64'd0);
        repeat (5) @(negedge clk);
        check_eq("abort quiet", 64'({bus.busy, bus.done}), 64'd0);

        run_op("post_abort", 1'b0, 16'd3, 16'd7, -1, 1'b0, r, e, lat);
        check_eq("post_abort res", 64'(r), 64'd5);
        check_eq("post_abort err", 64'(e), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
